cc_wb_arbiter: RTL and testbench

Write-back arbiter for the classical controller's register file. It merges two producers onto the file's single write port: the in-order execute-stage result, which is never stalled, and asynchronous qubit-measurement results from the readout path, which are buffered in a small FIFO. It also publishes a per-register pending mask so decode can stall reads of registers that still await a measurement result. It sits directly upstream of the 32×32 register file (two read ports, one write port, r0 hard-wired to zero).

---
 rtl/cc_pkg.sv | 20 ++
 rtl/cc_wb_fifo.sv | 72 +++++++
 rtl/cc_wb_arbiter.sv | 94 +++++++++
 tb/tb_cc_wb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared types and widths for the classical controller write-back path.
package cc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  // One buffered register-file write: destination and value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which producer loaded the current write-port contents.
  typedef enum logic {
    WB_ALU  = 1'b0,
    WB_MEAS = 1'b1
  } wb_src_e;

endpackage

// File: rtl/cc_wb_fifo.sv
// Measurement-result FIFO. It exposes every slot and a per-slot valid
// vector so the arbiter can build the pending-register mask.
module cc_wb_fifo
  import cc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0]            entry_valid,
  output wb_entry_t [DEPTH-1:0]       entries
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W-1:0] off;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // Flush wins over both push and pop on the same edge.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  // Payload storage; slots are qualified by entry_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid = '0;
    entries     = '0;
    off         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
      entries[i]     = mem[i];
    end
  end

endmodule

// File: rtl/cc_wb_arbiter.sv
// Register-file write-back arbiter: the execute stage always wins the single
// write port; measurement results queue in a FIFO and drain in idle cycles.
// A pending mask tells decode which registers still await a measurement.
module cc_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = cc_pkg::DATA_W,
  parameter int ADDR_W = cc_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    alu_wr_en,
  input  logic [ADDR_W-1:0]       alu_wr_addr,
  input  logic [DATA_W-1:0]       alu_wr_data,
  input  logic                    meas_valid,
  output logic                    meas_ready,
  input  logic [ADDR_W-1:0]       meas_addr,
  input  logic [DATA_W-1:0]       meas_data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [(2**ADDR_W)-1:0]  pending,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  import cc_pkg::*;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  wb_entry_t             fifo_head;
  wb_entry_t             push_entry;
  logic [DEPTH-1:0]      ent_vld;
  wb_entry_t [DEPTH-1:0] ents;
  wb_src_e               src;

  assign meas_ready = !fifo_full && !flush;
  // Writes to r0 are accepted so the readout path never stalls on them,
  // but they are dropped here and never mark r0 pending.
  assign fifo_push  = meas_valid && meas_ready && (meas_addr != '0);
  assign fifo_pop   = !alu_wr_en && !fifo_empty && !flush;
  assign push_entry = '{addr: meas_addr, data: meas_data};

  cc_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .push        (fifo_push),
    .push_entry  (push_entry),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_valid (ent_vld),
    .entries     (ents)
  );

  // Write-port register: ALU first, then FIFO head, otherwise idle with address/data held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      src     <= WB_ALU;
    end else if (alu_wr_en) begin
      wr_en   <= 1'b1;
      wr_addr <= alu_wr_addr;
      wr_data <= alu_wr_data;
      src     <= WB_ALU;
    end else if (fifo_pop) begin
      wr_en   <= 1'b1;
      wr_addr <= fifo_head.addr;
      wr_data <= fifo_head.data;
      src     <= WB_MEAS;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Pending mask: every buffered destination plus a measurement write still on the port.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pending[ents[i].addr] = 1'b1;
    end
    if (wr_en && (src == WB_MEAS)) pending[wr_addr] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_cc_wb_arbiter.sv
// Directed bench for cc_wb_arbiter with a write-port scoreboard.
module tb_cc_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        alu_wr_en;
  logic [4:0]  alu_wr_addr;
  logic [31:0] alu_wr_data;
  logic        meas_valid;
  logic        meas_ready;
  logic [4:0]  meas_addr;
  logic [31:0] meas_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  cc_wb_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .alu_wr_en   (alu_wr_en),
    .alu_wr_addr (alu_wr_addr),
    .alu_wr_data (alu_wr_data),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_addr   (meas_addr),
    .meas_data   (meas_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pending     (pending),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every register-file write must match the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got r%0d=0x%08h, want no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", {27'd0, wr_addr}, {27'd0, e.a});
        chk("wb_data", wr_data, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both producers active.
    reset_n     = 1'b0;
    flush       = 1'b0;
    alu_wr_en   = 1'b1;
    alu_wr_addr = 5'd6;
    alu_wr_data = 32'h0000_1234;
    meas_valid  = 1'b1;
    meas_addr   = 5'd7;
    meas_data   = 32'h1;
    repeat (3) step();
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_pending", pending, 32'd0);
    chk("reset_count", {29'd0, fifo_count}, 32'd0);
    alu_wr_en  = 1'b0;
    meas_valid = 1'b0;
    #2 reset_n = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, meas_ready}, 32'd1);

    // ALU-only write.
    alu_wr_en   = 1'b1;
    alu_wr_addr = 5'd3;
    alu_wr_data = 32'hDEAD_BEEF;
    exp_wr(5'd3, 32'hDEAD_BEEF);
    step();
    alu_wr_en = 1'b0;
    chk("alu_wr_en", {31'd0, wr_en}, 32'd1);
    step();
    chk("alu_idle", {31'd0, wr_en}, 32'd0);

    // Measurement latency and pending.
    meas_valid = 1'b1;
    meas_addr  = 5'd7;
    meas_data  = 32'h1;
    chk("meas_ready_idle", {31'd0, meas_ready}, 32'd1);
    exp_wr(5'd7, 32'h1);
    step();
    meas_valid = 1'b0;
    chk("meas_pend_e0", pending, 32'h80);
    chk("meas_no_bypass", {31'd0, wr_en}, 32'd0);
    chk("meas_count_e0", {29'd0, fifo_count}, 32'd1);
    step();
    chk("meas_pend_e1", pending, 32'h80);
    chk("meas_wr_e1", {31'd0, wr_en}, 32'd1);
    chk("meas_count_e1", {29'd0, fifo_count}, 32'd0);
    step();
    chk("meas_pend_e2", pending, 32'h0);
    chk("meas_idle_e2", {31'd0, wr_en}, 32'd0);

    // Priority and backpressure: ALU every cycle, FIFO fills, fifth offer held.
    for (int k = 0; k < 6; k++) begin
      alu_wr_en   = 1'b1;
      alu_wr_addr = 5'(20 + k);
      alu_wr_data = 32'hA000_0000 + k;
      exp_wr(5'(20 + k), 32'hA000_0000 + k);
      meas_valid = 1'b1;
      if (k < 4) begin
        meas_addr = 5'(k + 1);
        meas_data = 32'h100 + k + 1;
        chk("bp_ready_open", {31'd0, meas_ready}, 32'd1);
      end else begin
        meas_addr = 5'd5;
        meas_data = 32'h105;
        chk("bp_ready_full", {31'd0, meas_ready}, 32'd0);
      end
      step();
    end
    for (int m = 1; m <= 5; m++) exp_wr(5'(m), 32'h100 + m);
    alu_wr_en = 1'b0;
    chk("bp_count_full", {29'd0, fifo_count}, 32'd4);
    chk("bp_pending", pending, 32'h1E);
    chk("bp_ready_still", {31'd0, meas_ready}, 32'd0);
    step();
    chk("full_pop_no_push", {29'd0, fifo_count}, 32'd3);
    chk("bp_ready_reopen", {31'd0, meas_ready}, 32'd1);
    step();
    meas_valid = 1'b0;
    chk("bp_count_held", {29'd0, fifo_count}, 32'd3);
    repeat (3) step();
    chk("bp_drained", {29'd0, fifo_count}, 32'd0);
    step();
    chk("bp_idle", {31'd0, wr_en}, 32'd0);
    chk("bp_pend_clear", pending, 32'h0);

    // r0 measurement: accepted, no write, no pending.
    meas_valid = 1'b1;
    meas_addr  = 5'd0;
    meas_data  = 32'hFFFF;
    chk("r0_ready", {31'd0, meas_ready}, 32'd1);
    step();
    meas_valid = 1'b0;
    chk("r0_count", {29'd0, fifo_count}, 32'd0);
    chk("r0_pending", pending, 32'h0);
    step();
    chk("r0_no_write", {31'd0, wr_en}, 32'd0);

    // Flush with three buffered results and a concurrent ALU write.
    for (int k = 0; k < 3; k++) begin
      alu_wr_en   = 1'b1;
      alu_wr_addr = 5'(21 + k);
      alu_wr_data = 32'hB000_0000 + k;
      exp_wr(5'(21 + k), 32'hB000_0000 + k);
      meas_valid  = 1'b1;
      meas_addr   = 5'(10 + k);
      meas_data   = 32'h200 + k;
      step();
    end
    meas_valid = 1'b0;
    chk("fl_pending_pre", pending, 32'h1C00);
    chk("fl_count_pre", {29'd0, fifo_count}, 32'd3);
    flush       = 1'b1;
    alu_wr_addr = 5'd9;
    alu_wr_data = 32'h0000_0099;
    exp_wr(5'd9, 32'h0000_0099);
    #1;
    chk("fl_ready", {31'd0, meas_ready}, 32'd0);
    step();
    flush     = 1'b0;
    alu_wr_en = 1'b0;
    chk("fl_count", {29'd0, fifo_count}, 32'd0);
    chk("fl_pending", pending, 32'h0);
    chk("fl_alu_wr", {31'd0, wr_en}, 32'd1);
    step();
    chk("fl_no_stale1", {31'd0, wr_en}, 32'd0);
    step();
    chk("fl_no_stale2", {31'd0, wr_en}, 32'd0);

    step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
